// File: rtl/bf_pkg.sv
// Shared definitions for the Bellman-Ford output memory: record layout, widths
// and the reader FSM state encoding (also used by the engine's write side).
package bf_pkg;
    localparam int ADDR_W         = 13;
    localparam int DATA_W         = 128;
    localparam int BYTE_W         = 8;
    localparam int CNT_W          = ADDR_W + 1;
    localparam int BYTES_PER_WORD = DATA_W / BYTE_W;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

    localparam int OM_VALID_BIT = 127;
    localparam int OM_NODE_HI   = 126;
    localparam int OM_NODE_LO   = 119;
    localparam int OM_PRED_HI   = 118;
    localparam int OM_PRED_LO   = 111;
    localparam int OM_DIST_HI   = 110;
    localparam int OM_DIST_LO   = 95;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_FIN   = 3'd4
    } bf_state_e;

    function automatic logic om_valid(input logic [DATA_W-1:0] w);
        return w[OM_VALID_BIT];
    endfunction
endpackage

// File: rtl/bf_result_reader_if.sv
// Byte stream from the result reader to the host: valid/ready with a last flag.
interface bf_result_reader_if;
    logic [bf_pkg::BYTE_W-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/bf_word_serializer.sv
// Loads one output-memory word and emits it MSB-byte-first over valid/ready.
module bf_word_serializer
    import bf_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              ready_i,
    output logic [BYTE_W-1:0] data_o,
    output logic              valid_o,
    output logic [BIDX_W-1:0] byte_idx_o,
    output logic              fire_o,
    output logic              word_done_o
);
    logic [DATA_W-1:0] shreg_q;
    logic [BIDX_W-1:0] cnt_q;
    logic              valid_q;

    assign fire_o      = valid_q && ready_i;
    assign word_done_o = fire_o && (cnt_q == BIDX_W'(BYTES_PER_WORD - 1));
    assign data_o      = shreg_q[DATA_W-1 -: BYTE_W];
    assign valid_o     = valid_q;
    assign byte_idx_o  = cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shreg_q <= word_i;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (fire_o) begin
            shreg_q <= shreg_q << BYTE_W;
            cnt_q   <= cnt_q + BIDX_W'(1);
            if (word_done_o) valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/bf_result_reader.sv
// Reads the result table out of output memory, optionally drops invalid
// records, and streams the kept ones to the host one byte at a time.
module bf_result_reader
    import bf_pkg::*;
#(
    parameter bit SKIP_INVALID = 1'b1
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_sent,
    output logic [ADDR_W-1:0] OMRAR,
    input  logic [DATA_W-1:0] OMRDR,
    bf_result_reader_if.master out_if
);
    bf_state_e         state_q;
    logic              busy_q, done_q, last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  rem_q, sent_q;
    logic [CNT_W-1:0]  rem_d;
    logic              keep, ser_load, ser_fire, ser_word_done, ser_valid;
    logic [BIDX_W-1:0] ser_idx;
    logic [BYTE_W-1:0] ser_data;

    assign rem_d    = rem_q - CNT_W'(1);
    assign keep     = !SKIP_INVALID || om_valid(OMRDR);
    assign ser_load = (state_q == ST_LATCH) && keep;

    bf_word_serializer u_ser (
        .clk_i       (clock),
        .rst_ni      (reset),
        .load_i      (ser_load),
        .word_i      (OMRDR),
        .ready_i     (out_if.out_ready),
        .data_o      (ser_data),
        .valid_o     (ser_valid),
        .byte_idx_o  (ser_idx),
        .fire_o      (ser_fire),
        .word_done_o (ser_word_done)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            sent_q  <= '0;
        end else begin
            done_q <= 1'b0;
            // last flag goes up with byte 15 of the final record and is held through stalls
            if (ser_fire)
                last_q <= (ser_idx == BIDX_W'(BYTES_PER_WORD - 2)) && (rem_q == '0);
            case (state_q)
                ST_IDLE: if (start) begin
                    rem_q  <= word_count;
                    sent_q <= '0;
                    if (word_count == '0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        addr_q  <= base_addr;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: state_q <= ST_LATCH;
                ST_LATCH: begin
                    rem_q <= rem_d;
                    if (keep) begin
                        state_q <= ST_SEND;
                    end else if (rem_d != '0) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= ST_FETCH;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_SEND: if (ser_word_done) begin
                    sent_q <= sent_q + CNT_W'(1);
                    if (rem_q != '0) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= ST_FETCH;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign words_sent       = sent_q;
    assign OMRAR            = addr_q;
    assign out_if.out_data  = ser_data;
    assign out_if.out_valid = ser_valid;
    assign out_if.out_last  = last_q;
endmodule

// File: tb/tb_bf_result_reader.sv
// Directed bench for bf_result_reader: synchronous memory model, byte collector
// with stall-stability checks, and hand-computed latencies per job.
module tb_bf_result_reader;
    import bf_pkg::*;

    logic              clock = 1'b0;
    logic              reset, start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              busy, done;
    logic [CNT_W-1:0]  words_sent;
    logic [ADDR_W-1:0] OMRAR;
    logic [DATA_W-1:0] OMRDR;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    bf_result_reader_if sif ();

    int         n_tot = 0;
    int         n_bad = 0;
    bit         rdy_rand = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         last_q[$];
    int         cyc;
    logic [ADDR_W-1:0] prev_addr;

    always #5 clock = ~clock;

    bf_result_reader #(.SKIP_INVALID(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent),
        .OMRAR      (OMRAR),
        .OMRDR      (OMRDR),
        .out_if     (sif)
    );

    always @(posedge clock) OMRDR <= mem[OMRAR];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_rec(input logic [ADDR_W-1:0] a, input bit vld);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < BYTES_PER_WORD; k++)
            w[DATA_W-1-8*k -: 8] = a[7:0] + 8'(k * 37) + 8'h11;
        w[OM_VALID_BIT] = vld;
        return w;
    endfunction

    task automatic add_exp(input logic [ADDR_W-1:0] a);
        for (int k = 0; k < BYTES_PER_WORD; k++)
            exp_q.push_back(mem[a][DATA_W-1-8*k -: 8]);
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
        last_q.delete();
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
        @(posedge clock); #1;
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int c);
        c = 0;
        while (!done && c < limit) begin
            @(posedge clock); #1;
            c++;
        end
        check_val("done_seen", done, 1);
    endtask

    task automatic check_stream(input string tag, input bit exp_last);
        int nl = 0;
        check_val({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_val($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
        foreach (last_q[i]) nl += int'(last_q[i]);
        check_val({tag, "_nlast"}, nl, exp_last ? 1 : 0);
        if (exp_last && last_q.size() > 0)
            check_val({tag, "_lastpos"}, last_q[last_q.size()-1], 1);
    endtask

    // Sink ready, changed just after each rising edge.
    initial begin
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            sif.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Collector: a byte is taken when valid&&ready is seen half a cycle before the edge.
    initial begin
        logic [7:0] pd;
        bit pl, ps;
        ps = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clock);
            if (ps) begin
                check_val("hold_valid", sif.out_valid, 1);
                check_val("hold_data", sif.out_data, pd);
                check_val("hold_last", sif.out_last, pl);
            end
            if (sif.out_valid && sif.out_ready) begin
                got_q.push_back(sif.out_data);
                last_q.push_back(sif.out_last);
            end
            ps = sif.out_valid && !sif.out_ready && reset;
            pd = sif.out_data;
            pl = sif.out_last;
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        for (int a = 'h10; a <= 'h12; a++) mem[a] = mk_rec(13'(a), 1'b1);
        for (int a = 'h20; a <= 'h23; a++) mem[a] = mk_rec(13'(a), a != 'h21);
        mem['h30] = mk_rec(13'h30, 1'b1);
        mem['h31] = mk_rec(13'h31, 1'b0);
        for (int a = 'h40; a <= 'h42; a++) mem[a] = mk_rec(13'(a), 1'b1);
        mem['h50]  = mk_rec(13'h50, 1'b1);
        mem['h51]  = mk_rec(13'h51, 1'b1);
        mem['h1FFF] = mk_rec(13'h1FFF, 1'b1);
        mem['h0000] = mk_rec(13'h0000, 1'b1);

        repeat (3) @(posedge clock);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_valid", sif.out_valid, 0);
        check_val("rst_last", sif.out_last, 0);
        check_val("rst_data", sif.out_data, 0);
        check_val("rst_omrar", OMRAR, 0);
        check_val("rst_sent", words_sent, 0);
        reset = 1'b1;

        // Three valid records; a start mid-job must be ignored. 3 x (2 + 16) = 54 cycles.
        clear_q();
        for (int a = 'h10; a <= 'h12; a++) add_exp(13'(a));
        start_job(13'h010, 14'd3);
        check_val("t1_busy", busy, 1);
        check_val("t1_omrar", OMRAR, 'h10);
        repeat (10) begin @(posedge clock); #1; end
        base_addr = 13'h100; word_count = 14'd1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(200, cyc);
        check_val("t1_lat", cyc + 11, 54);
        check_val("t1_busy_fin", busy, 0);
        check_val("t1_sent", words_sent, 3);
        check_stream("t1", 1'b1);
        @(posedge clock); #1;
        check_val("t1_done_pulse", done, 0);

        // Empty job: straight to FIN, address untouched, sent count cleared.
        clear_q();
        prev_addr = OMRAR;
        start_job(13'h077, 14'd0);
        check_val("t2_done", done, 1);
        check_val("t2_busy", busy, 0);
        check_val("t2_omrar", OMRAR, prev_addr);
        check_val("t2_sent", words_sent, 0);
        @(posedge clock); #1;
        check_val("t2_done_pulse", done, 0);
        check_val("t2_nbytes", got_q.size(), 0);

        // Middle record invalid: 18 + 2 + 18 + 18 = 56 cycles.
        clear_q();
        add_exp(13'h20); add_exp(13'h22); add_exp(13'h23);
        start_job(13'h020, 14'd4);
        wait_done(200, cyc);
        check_val("t3_lat", cyc, 56);
        check_val("t3_sent", words_sent, 3);
        check_stream("t3", 1'b1);

        // Trailing record invalid: no last flag, only done marks the end.
        clear_q();
        add_exp(13'h30);
        start_job(13'h030, 14'd2);
        wait_done(200, cyc);
        check_val("t4_lat", cyc, 20);
        check_val("t4_sent", words_sent, 1);
        check_stream("t4", 1'b0);

        // Address wrap 0x1FFF -> 0x0000.
        clear_q();
        add_exp(13'h1FFF); add_exp(13'h0000);
        start_job(13'h1FFF, 14'd2);
        wait_done(200, cyc);
        check_val("t5_lat", cyc, 36);
        check_val("t5_omrar", OMRAR, 0);
        check_val("t5_sent", words_sent, 2);
        check_stream("t5", 1'b1);

        // Random backpressure.
        clear_q();
        add_exp(13'h50); add_exp(13'h51);
        rdy_rand = 1'b1;
        start_job(13'h050, 14'd2);
        wait_done(3000, cyc);
        rdy_rand = 1'b0;
        check_val("t6_sent", words_sent, 2);
        check_stream("t6", 1'b1);

        // Reset while byte 5 of record 2 is on the bus.
        clear_q();
        start_job(13'h040, 14'd3);
        cyc = 0;
        while (got_q.size() < 21 && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        check_val("t7_reach", got_q.size(), 21);
        reset = 1'b0;
        @(posedge clock); #1;
        check_val("t7_busy", busy, 0);
        check_val("t7_valid", sif.out_valid, 0);
        check_val("t7_done", done, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check_val("t7_nodone", done, 0);
        end
        check_val("t7_omrar", OMRAR, 0);
        check_val("t7_sent", words_sent, 0);
        clear_q();
        for (int a = 'h40; a <= 'h42; a++) add_exp(13'(a));
        start_job(13'h040, 14'd3);
        wait_done(200, cyc);
        check_val("t7_lat", cyc, 54);
        check_val("t7_sent_full", words_sent, 3);
        check_stream("t7", 1'b1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
